// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - in-order instruction fetch queue between PC stage and decode
// Issues one ROM read per predicted PC and holds returned words with their metadata until decode.
module inst_fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int GHR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  pred_taken_in,
  input  logic [GHR_WIDTH-1:0]  pht_index_in,
  output logic                  stall_out,
  input  logic                  flush,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic                  rom_ready,
  input  logic                  rom_rvalid,
  input  logic [31:0]           rom_rdata,
  output logic                  inst_valid,
  output logic [31:0]           inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc_out,
  output logic                  pred_taken_out,
  output logic [GHR_WIDTH-1:0]  pht_index_out,
  output logic                  addr_err_out,
  input  logic                  id_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW+1:0] FULL_OCC = (PW+2)'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q     [DEPTH];
  logic                  pred_q   [DEPTH];
  logic [GHR_WIDTH-1:0]  idx_q    [DEPTH];
  logic [31:0]           inst_q   [DEPTH];
  logic                  err_q    [DEPTH];
  logic                  filled_q [DEPTH];

  logic [PW-1:0] head, fill, tail;
  logic [PW:0]   count, pend, discard;

  logic          aligned, alloc_rom, alloc_err, alloc, pop;
  logic          fill_en, drop, proto_err;
  logic [PW+1:0] occupancy, discard_flush;

  // pend tracks unfilled in-flight entries; fill==tail alone is ambiguous when all DEPTH are in flight
  always_comb begin
    aligned   = (pc_in[1:0] == 2'b00);
    occupancy = {1'b0, count} + {1'b0, discard};
    rom_en    = !rst && !flush && aligned && (occupancy < FULL_OCC);
    rom_addr  = rst ? '0 : pc_in;
    alloc_rom = rom_en && rom_ready;
    alloc_err = !rst && !flush && !aligned && (count < FULL_CNT) && (pend == '0);
    alloc     = alloc_rom || alloc_err;
    stall_out = !alloc;
    inst_valid = filled_q[head] && (count != '0) && !flush;
    pop       = inst_valid && id_ready;
    fill_en   = rom_rvalid && !flush && (discard == '0) && (pend != '0);
    drop      = rom_rvalid && !flush && (discard != '0);
    proto_err = rom_rvalid && (discard == '0) && (pend == '0);
    discard_flush = {1'b0, discard} + {1'b0, pend};
    if (rom_rvalid && (discard_flush != '0)) discard_flush = discard_flush - 1'b1;
  end

  assign inst_out       = inst_q[head];
  assign inst_pc_out    = pc_q[head];
  assign pred_taken_out = pred_q[head];
  assign pht_index_out  = idx_q[head];
  assign addr_err_out   = err_q[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      fill    <= '0;
      tail    <= '0;
      count   <= '0;
      pend    <= '0;
      discard <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]     <= '0;
        pred_q[i]   <= 1'b0;
        idx_q[i]    <= '0;
        inst_q[i]   <= '0;
        err_q[i]    <= 1'b0;
        filled_q[i] <= 1'b0;
      end
    end else if (flush) begin
      head    <= '0;
      fill    <= '0;
      tail    <= '0;
      count   <= '0;
      pend    <= '0;
      // every request still owed by the ROM, minus one returning right now, belongs to the wrong path
      discard <= discard_flush[PW:0];
      for (int i = 0; i < DEPTH; i++) filled_q[i] <= 1'b0;
    end else begin
      if (pop) begin
        filled_q[head] <= 1'b0;
        head           <= head + 1'b1;
      end
      if (alloc) begin
        pc_q[tail]     <= pc_in;
        pred_q[tail]   <= pred_taken_in;
        idx_q[tail]    <= pht_index_in;
        inst_q[tail]   <= '0;
        err_q[tail]    <= alloc_err;
        filled_q[tail] <= alloc_err;
        tail           <= tail + 1'b1;
        if (alloc_err) fill <= fill + 1'b1;
      end
      if (fill_en) begin
        inst_q[fill]   <= rom_rdata;
        filled_q[fill] <= 1'b1;
        fill           <= fill + 1'b1;
      end
      if (drop) discard <= discard - 1'b1;
      if (alloc && !pop) count <= count + 1'b1;
      else if (!alloc && pop) count <= count - 1'b1;
      if (alloc_rom && !fill_en) pend <= pend + 1'b1;
      else if (!alloc_rom && fill_en) pend <= pend - 1'b1;
    end
  end

  // a response with nothing outstanding means the ROM broke ordering
  always @(posedge clk) begin
    if (!rst) assert (!proto_err);
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed table, corner sequences and randomized model check
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic        pred_taken_in = 1'b0;
  logic [7:0]  pht_index_in = '0;
  logic        stall_out, flush = 1'b0;
  logic        rom_en, rom_ready = 1'b0, rom_rvalid = 1'b0;
  logic [31:0] rom_addr, rom_rdata = '0;
  logic        inst_valid, pred_taken_out, addr_err_out;
  logic [31:0] inst_out, inst_pc_out;
  logic [7:0]  pht_index_out;
  logic        id_ready = 1'b0;

  inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .GHR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pred_taken_in(pred_taken_in),
    .pht_index_in(pht_index_in), .stall_out(stall_out), .flush(flush),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_ready(rom_ready),
    .rom_rvalid(rom_rvalid), .rom_rdata(rom_rdata), .inst_valid(inst_valid),
    .inst_out(inst_out), .inst_pc_out(inst_pc_out), .pred_taken_out(pred_taken_out),
    .pht_index_out(pht_index_out), .addr_err_out(addr_err_out), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic fl, input logic rr,
                       input logic rv, input logic [31:0] rd, input logic idr);
    pc_in = pc; flush = fl; rom_ready = rr; rom_rvalid = rv; rom_rdata = rd; id_ready = idr;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pred_taken_in = 1'b0; pht_index_in = '0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc; logic rr; logic rv; logic [31:0] rd; logic idr;
    logic e_stall; logic e_en; logic e_iv; logic [31:0] e_inst; logic [31:0] e_pc;
  } vec_t;
  vec_t vt[15];

  typedef struct {
    logic [31:0] pc; logic pred; logic [7:0] idx; logic [31:0] inst; logic err; logic filled;
  } ent_t;
  typedef struct { logic [31:0] addr; logic stale; } req_t;
  ent_t mq[$];
  req_t rq[$];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  initial begin
    vt[0]  = '{32'h1000, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
    vt[1]  = '{32'h1004, 1'b1, 1'b1, 32'hAAAA0001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
    vt[2]  = '{32'h1008, 1'b1, 1'b1, 32'hBBBB0002, 1'b1, 1'b0, 1'b1, 1'b1, 32'hAAAA0001, 32'h1000};
    vt[3]  = '{32'h100C, 1'b0, 1'b1, 32'hCCCC0003, 1'b1, 1'b1, 1'b1, 1'b1, 32'hBBBB0002, 32'h1004};
    vt[4]  = '{32'h100C, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'hCCCC0003, 32'h1008};
    vt[5]  = '{32'h100C, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0};
    vt[6]  = '{32'h2000, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
    vt[7]  = '{32'h2004, 1'b1, 1'b1, 32'hD0D00000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
    vt[8]  = '{32'h2008, 1'b1, 1'b1, 32'hD1D10001, 1'b0, 1'b0, 1'b1, 1'b1, 32'hD0D00000, 32'h2000};
    vt[9]  = '{32'h200C, 1'b1, 1'b1, 32'hD2D20002, 1'b0, 1'b0, 1'b1, 1'b1, 32'hD0D00000, 32'h2000};
    vt[10] = '{32'h2010, 1'b1, 1'b1, 32'hD3D30003, 1'b0, 1'b1, 1'b0, 1'b1, 32'hD0D00000, 32'h2000};
    vt[11] = '{32'h2010, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'hD0D00000, 32'h2000};
    vt[12] = '{32'h2010, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hD0D00000, 32'h2000};
    vt[13] = '{32'h2010, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hD1D10001, 32'h2004};
    vt[14] = '{32'h2014, 1'b1, 1'b1, 32'hD4D40004, 1'b0, 1'b1, 1'b0, 1'b1, 32'hD1D10001, 32'h2004};

    // reset state
    #2;
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_stall", stall_out, 1'b1);
    chk("rst_rom_en", rom_en, 1'b0);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pc", inst_pc_out, 32'h0);
    chk("rst_err", addr_err_out, 1'b0);
    do_reset();

    // streaming and full-queue table
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].pc, 1'b0, vt[i].rr, vt[i].rv, vt[i].rd, vt[i].idr);
      #1;
      chk($sformatf("vec%0d_stall", i), stall_out, vt[i].e_stall);
      chk($sformatf("vec%0d_rom_en", i), rom_en, vt[i].e_en);
      chk($sformatf("vec%0d_inst_valid", i), inst_valid, vt[i].e_iv);
      if (vt[i].e_iv) begin
        chk($sformatf("vec%0d_inst", i), inst_out, vt[i].e_inst);
        chk($sformatf("vec%0d_pc", i), inst_pc_out, vt[i].e_pc);
      end
      tick();
    end

    // flush with 3 in flight, no response in the flush cycle
    do_reset();
    drive(32'h3000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1); tick();
    drive(32'h3004, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1); tick();
    drive(32'h3008, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1); tick();
    drive(32'h300C, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1); #1;
    chk("fl3_stall", stall_out, 1'b1);
    chk("fl3_rom_en", rom_en, 1'b0);
    tick();
    drive(32'h80000180, 1'b0, 1'b1, 1'b1, 32'hDEAD0001, 1'b1); #1;
    chk("fl3_new_issue", stall_out, 1'b0);
    tick();
    drive(32'h80000184, 1'b0, 1'b0, 1'b1, 32'hDEAD0002, 1'b1); #1;
    chk("fl3_drop1", inst_valid, 1'b0); tick();
    drive(32'h80000184, 1'b0, 1'b0, 1'b1, 32'hDEAD0003, 1'b1); #1;
    chk("fl3_drop2", inst_valid, 1'b0); tick();
    drive(32'h80000184, 1'b0, 1'b0, 1'b1, 32'hE0E0E0E0, 1'b1); #1;
    chk("fl3_drop3", inst_valid, 1'b0); tick();
    drive(32'h80000184, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
    chk("fl3_valid", inst_valid, 1'b1);
    chk("fl3_inst", inst_out, 32'hE0E0E0E0);
    chk("fl3_pc", inst_pc_out, 32'h80000180);
    tick();

    // flush coinciding with a response, 2 in flight
    do_reset();
    drive(32'h4000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1); tick();
    drive(32'h4004, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1); tick();
    drive(32'h4008, 1'b1, 1'b1, 1'b1, 32'hDEAD0004, 1'b1); tick();
    drive(32'h5000, 1'b0, 1'b1, 1'b1, 32'hDEAD0005, 1'b1); #1;
    chk("flr_rom_en", rom_en, 1'b1); tick();
    drive(32'h5004, 1'b0, 1'b0, 1'b1, 32'hF0F0F0F0, 1'b1); #1;
    chk("flr_drop", inst_valid, 1'b0); tick();
    drive(32'h5004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
    chk("flr_valid", inst_valid, 1'b1);
    chk("flr_inst", inst_out, 32'hF0F0F0F0);
    chk("flr_pc", inst_pc_out, 32'h5000);
    tick();

    // misaligned PC behind one outstanding fetch
    do_reset();
    drive(32'h1000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); #1;
    chk("mis_first_issue", stall_out, 1'b0); tick();
    drive(32'h1002, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); #1;
    chk("mis_wait_stall", stall_out, 1'b1);
    chk("mis_no_rom", rom_en, 1'b0); tick();
    drive(32'h1002, 1'b0, 1'b1, 1'b1, 32'hAAAA0001, 1'b0); #1;
    chk("mis_fill_stall", stall_out, 1'b1); tick();
    drive(32'h1002, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1); #1;
    chk("mis_alloc", stall_out, 1'b0);
    chk("mis_prior_valid", inst_valid, 1'b1);
    chk("mis_prior_inst", inst_out, 32'hAAAA0001);
    chk("mis_prior_pc", inst_pc_out, 32'h1000); tick();
    drive(32'h1010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
    chk("mis_err_valid", inst_valid, 1'b1);
    chk("mis_err_inst", inst_out, 32'h0);
    chk("mis_err_flag", addr_err_out, 1'b1);
    chk("mis_err_pc", inst_pc_out, 32'h1002); tick();

    // asynchronous reset mid-stream
    do_reset();
    drive(32'h7000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); tick();
    drive(32'h7004, 1'b0, 1'b1, 1'b1, 32'h70700000, 1'b0); tick();
    drive(32'h7008, 1'b0, 1'b0, 1'b1, 32'h70700004, 1'b0); #1;
    chk("ar_pre_valid", inst_valid, 1'b1); tick();
    drive(32'h7008, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid_drop", inst_valid, 1'b0);
    chk("ar_stall", stall_out, 1'b1);
    chk("ar_rom_en", rom_en, 1'b0);
    chk("ar_inst", inst_out, 32'h0);
    chk("ar_pc", inst_pc_out, 32'h0);
    tick();
    rst = 1'b0;
    drive(32'h6000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1); #1;
    chk("ar_restart_en", rom_en, 1'b1);
    chk("ar_restart_empty", inst_valid, 1'b0); tick();
    drive(32'h6004, 1'b0, 1'b0, 1'b1, 32'h60600000, 1'b1); tick();
    drive(32'h6004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
    chk("ar_first_valid", inst_valid, 1'b1);
    chk("ar_first_inst", inst_out, 32'h60600000);
    chk("ar_first_pc", inst_pc_out, 32'h6000); tick();

    // randomized traffic against a queue-level reference model
    do_reset();
    mq.delete(); rq.delete();
    begin
      logic [31:0] npc;
      logic new_pc;
      new_pc = 1'b1;
      npc = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        int n_stale;
        logic any_unfilled, al, e_en, e_alloc, e_iv, fl, rr, rv, idr;
        logic [31:0] rd;
        if (new_pc) begin
          npc = $urandom();
          npc[1:0] = ($urandom % 8 == 0) ? 2'b10 : 2'b00;
          pred_taken_in = 1'($urandom % 2);
          pht_index_in = 8'($urandom);
        end
        fl  = ($urandom % 16 == 0);
        rr  = ($urandom % 4 != 0);
        rv  = (rq.size() > 0) && ($urandom % 2 == 0);
        rd  = rv ? rom_word(rq[0].addr) : 32'h0;
        idr = ($urandom % 3 != 0);
        n_stale = 0;
        foreach (rq[k]) if (rq[k].stale) n_stale++;
        any_unfilled = 1'b0;
        foreach (mq[k]) if (!mq[k].filled) any_unfilled = 1'b1;
        al = (npc[1:0] == 2'b00);
        e_en = !fl && al && (mq.size() + n_stale < DEPTH);
        e_alloc = (e_en && rr) || (!fl && !al && mq.size() < DEPTH && !any_unfilled);
        e_iv = !fl && mq.size() > 0 && mq[0].filled;
        drive(npc, fl, rr, rv, rd, idr);
        #1;
        chk("rnd_rom_en", rom_en, e_en);
        chk("rnd_stall", stall_out, !e_alloc);
        chk("rnd_inst_valid", inst_valid, e_iv);
        if (e_en) chk("rnd_rom_addr", rom_addr, npc);
        if (e_iv) begin
          chk("rnd_inst", inst_out, mq[0].inst);
          chk("rnd_pc", inst_pc_out, mq[0].pc);
          chk("rnd_pred", pred_taken_out, mq[0].pred);
          chk("rnd_idx", pht_index_out, mq[0].idx);
          chk("rnd_err", addr_err_out, mq[0].err);
        end
        tick();
        if (fl) begin
          if (rv) void'(rq.pop_front());
          foreach (rq[k]) rq[k].stale = 1'b1;
          mq.delete();
        end else begin
          if (e_iv && idr) void'(mq.pop_front());
          if (rv) begin
            req_t r;
            r = rq.pop_front();
            if (!r.stale) begin
              for (int k = 0; k < mq.size(); k++) begin
                if (!mq[k].filled) begin
                  mq[k].inst = rd;
                  mq[k].filled = 1'b1;
                  break;
                end
              end
            end
          end
          if (e_alloc) begin
            mq.push_back('{npc, pred_taken_in, pht_index_in, 32'h0, !al, !al});
            if (al) rq.push_back('{npc, 1'b0});
          end
        end
        new_pc = e_alloc || fl;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
